axi_rd_slice: RTL

Registered AXI read-channel slice between the prefetcher's master AR/R ports and the memory controller. Cuts combinational paths on AR and R with 2-entry skid buffers. Caps the number of in-flight read bursts and tracks them. Flags protocol errors on the response side, so DDR-side timing and outstanding depth are controlled independently of the prefetcher.

---
 rtl/axi_rd_slice.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_slice.sv
// axi_rd_slice: registered AXI read-channel slice.
// AR (prefetcher -> memory) and R (memory -> prefetcher) each pass through a
// 2-entry skid buffer. AR issue is held once MAX bursts are in flight, and the
// in-flight count is closed by R last beats. errorCode is sticky until reset:
//   bit0  R beat accepted with nothing outstanding (orphan)
//   bit1  R last does not line up with the head burst length
// Optional feature macro: RD_SLICE_LAST_CHECK_EN (bit1 checking). When it is
// undefined, bit1 is tied to 0 and no length FIFO or beat counter is built.

// Skid buffer states
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   ONE   | main register holds the oldest entry, skid empty
//   FULL  | main and skid both hold entries, input stalled
module axi_rd_slice_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // bit0 of the encoding doubles as the registered out_valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } skid_state_e;

   skid_state_e      state;
   skid_state_e      state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q;
   logic             in_hs;
   logic             out_hs;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   assign in_hs     = in_valid && in_ready_q;
   assign out_hs    = state[0] && out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = state[0];
   assign out_data  = main_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (in_hs) state_nxt = ST_ONE;
         ST_ONE: begin
            if (in_hs && !out_hs)      state_nxt = ST_FULL;
            else if (!in_hs && out_hs) state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (out_hs) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Output decode: which register loads from where this cycle
   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         ST_EMPTY: load_main_in = in_hs;
         ST_ONE: begin
            load_main_in = in_hs && out_hs;
            load_skid    = in_hs && !out_hs;
         end
         ST_FULL:  load_main_skid = out_hs;
         default: ;
      endcase
   end

   // Payload registers; held stable until the output handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= in_data;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

   // Registered ready: only the next state decides it, never out_ready directly
   always_ff @(posedge clk) begin
      if (reset) in_ready_q <= 1'b0;
      else       in_ready_q <= (state_nxt != ST_FULL);
   end

endmodule

module axi_rd_slice #(
   parameter int ADDR_BITS            = 64,
   parameter int BURST_LEN_WIDTH      = 8,
   parameter int TID_WIDTH            = 4,
   parameter int BLOCK_DATA_SIZE_BITS = 512,
   parameter int LOG_MAX_OUTSTANDING  = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            s_ar_valid,
   output logic                            s_ar_ready,
   input  logic [BURST_LEN_WIDTH-1:0]      s_ar_len,
   input  logic [ADDR_BITS-1:0]            s_ar_addr,
   input  logic [TID_WIDTH-1:0]            s_ar_id,
   output logic                            m_ar_valid,
   input  logic                            m_ar_ready,
   output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
   output logic [ADDR_BITS-1:0]            m_ar_addr,
   output logic [TID_WIDTH-1:0]            m_ar_id,
   input  logic                            m_r_valid,
   output logic                            m_r_ready,
   input  logic                            m_r_last,
   input  logic [BLOCK_DATA_SIZE_BITS-1:0] m_r_data,
   input  logic [TID_WIDTH-1:0]            m_r_id,
   output logic                            s_r_valid,
   input  logic                            s_r_ready,
   output logic                            s_r_last,
   output logic [BLOCK_DATA_SIZE_BITS-1:0] s_r_data,
   output logic [TID_WIDTH-1:0]            s_r_id,
   output logic [LOG_MAX_OUTSTANDING:0]    outstandingCnt,
   output logic [1:0]                      errorCode
);

   localparam int AR_W = BURST_LEN_WIDTH + ADDR_BITS + TID_WIDTH;
   localparam int R_W  = 1 + BLOCK_DATA_SIZE_BITS + TID_WIDTH;
   localparam logic [LOG_MAX_OUTSTANDING:0] MAX_CNT = {1'b1, {LOG_MAX_OUTSTANDING{1'b0}}};
   localparam logic [LOG_MAX_OUTSTANDING:0] CNT_ONE = {{LOG_MAX_OUTSTANDING{1'b0}}, 1'b1};

   logic            ar_out_valid;
   logic [AR_W-1:0] ar_out_data;
   logic [R_W-1:0]  r_out_data;
   logic            cap_ok;
   logic            m_ar_hs;
   logic            m_r_hs;
   logic            cnt_inc;
   logic            cnt_dec;
   logic            err_orphan_q;
   logic            err_last;

   // Cap compare uses the registered count only
   assign cap_ok     = (outstandingCnt < MAX_CNT);
   assign m_ar_valid = ar_out_valid && cap_ok;
   assign m_ar_hs    = m_ar_valid && m_ar_ready;
   assign m_r_hs     = m_r_valid && m_r_ready;
   assign cnt_inc    = m_ar_hs;
   // An orphan last beat must not underflow the count
   assign cnt_dec    = m_r_hs && m_r_last && (outstandingCnt != '0);

   axi_rd_slice_skid #(.WIDTH(AR_W)) u_ar_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_ar_valid),
      .in_ready  (s_ar_ready),
      .in_data   ({s_ar_len, s_ar_addr, s_ar_id}),
      .out_valid (ar_out_valid),
      .out_ready (m_ar_ready && cap_ok),
      .out_data  (ar_out_data)
   );

   assign {m_ar_len, m_ar_addr, m_ar_id} = ar_out_data;

   axi_rd_slice_skid #(.WIDTH(R_W)) u_r_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (m_r_valid),
      .in_ready  (m_r_ready),
      .in_data   ({m_r_last, m_r_data, m_r_id}),
      .out_valid (s_r_valid),
      .out_ready (s_r_ready),
      .out_data  (r_out_data)
   );

   assign {s_r_last, s_r_data, s_r_id} = r_out_data;

   // In-flight burst count: issue on m_ar, close on m_r last
   always_ff @(posedge clk) begin
      if (reset) begin
         outstandingCnt <= '0;
      end else begin
         case ({cnt_inc, cnt_dec})
            2'b10:   outstandingCnt <= outstandingCnt + CNT_ONE;
            2'b01:   outstandingCnt <= outstandingCnt - CNT_ONE;
            default: outstandingCnt <= outstandingCnt;
         endcase
      end
   end

   // Sticky orphan flag
   always_ff @(posedge clk) begin
      if (reset)                                   err_orphan_q <= 1'b0;
      else if (m_r_hs && (outstandingCnt == '0))   err_orphan_q <= 1'b1;
   end

`ifdef RD_SLICE_LAST_CHECK_EN
   // Length FIFO occupancy equals outstandingCnt: same push and pop events
   logic [BURST_LEN_WIDTH-1:0]     len_fifo [(1 << LOG_MAX_OUTSTANDING)];
   logic [LOG_MAX_OUTSTANDING-1:0] wr_ptr;
   logic [LOG_MAX_OUTSTANDING-1:0] rd_ptr;
   logic [BURST_LEN_WIDTH:0]       beat_cnt;
   logic [BURST_LEN_WIDTH:0]       head_len;
   logic                           head_valid;
   logic                           last_bad;
   logic                           err_last_q;

   localparam logic [LOG_MAX_OUTSTANDING-1:0] PTR_ONE = {{(LOG_MAX_OUTSTANDING-1){1'b0}}, 1'b1};
   localparam logic [BURST_LEN_WIDTH:0]       BEAT_ONE = {{BURST_LEN_WIDTH{1'b0}}, 1'b1};

   assign head_valid = (outstandingCnt != '0);
   assign head_len   = {1'b0, len_fifo[rd_ptr]};
   assign last_bad   = m_r_last ? (beat_cnt != head_len) : (beat_cnt == head_len);

   // FIFO storage needs no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (m_ar_hs) len_fifo[wr_ptr] <= m_ar_len;
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (m_ar_hs) wr_ptr <= wr_ptr + PTR_ONE;
         if (cnt_dec) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Beat index within the head burst; orphan beats are not counted
   always_ff @(posedge clk) begin
      if (reset)                      beat_cnt <= '0;
      else if (m_r_hs && m_r_last)    beat_cnt <= '0;
      else if (m_r_hs && head_valid)  beat_cnt <= beat_cnt + BEAT_ONE;
   end

   // Sticky last-mismatch flag
   always_ff @(posedge clk) begin
      if (reset)                                 err_last_q <= 1'b0;
      else if (m_r_hs && head_valid && last_bad) err_last_q <= 1'b1;
   end

   assign err_last = err_last_q;
`else
   assign err_last = 1'b0;
`endif

   assign errorCode = {err_last, err_orphan_q};

endmodule
